// File: rtl/caliptra_prim_alert_sender_mc.sv
`default_nettype none
// caliptra_prim_alert_sender_mc: multi-channel differential alert sender with ping
// response, fatal latching and a per-channel handshake timeout.  Rev 1.0
package caliptra_prim_alert_pkg;
   typedef struct packed {
      logic ping_p;
      logic ping_n;
      logic ack_p;
      logic ack_n;
   } alert_rx_t;

   typedef struct packed {
      logic alert_p;
      logic alert_n;
   } alert_tx_t;
endpackage

module caliptra_prim_alert_sender_mc
   import caliptra_prim_alert_pkg::*;
#(
   parameter int unsigned          NumAlerts   = 4,
   parameter logic [NumAlerts-1:0] FatalMask   = '0,
   parameter int unsigned          PauseCycles = 2,
   parameter int unsigned          TimeoutW    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NumAlerts-1:0] alert_test_i,
   input  logic [NumAlerts-1:0] alert_req_i,
   output logic [NumAlerts-1:0] alert_ack_o,
   output logic [NumAlerts-1:0] alert_state_o,
   input  logic [TimeoutW-1:0]  timeout_cycles_i,
   output logic [NumAlerts-1:0] timeout_o,
   input  logic [NumAlerts-1:0] timeout_clr_i,
   input  alert_rx_t            alert_rx_i [NumAlerts],
   output alert_tx_t            alert_tx_o [NumAlerts]
);

   typedef enum logic [2:0] {
      Idle     = 3'd0,
      AlertHs1 = 3'd1,
      AlertHs2 = 3'd2,
      PingHs1  = 3'd3,
      PingHs2  = 3'd4,
      Pause    = 3'd5
   } state_e;

   localparam logic [3:0] PauseLast = 4'(PauseCycles - 1);

   for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
      state_e              state;
      logic                alert_p, alert_n;
      logic                ping_level_q;
      logic                set_q, test_q, ping_q;
      logic                alert_clr, ping_clr;
      logic                timeout_q;
      logic [TimeoutW-1:0] hs_cnt;
      logic [3:0]          pause_cnt;

      logic                ping_sigint, ack_sigint, sigint;
      logic                ack_level, ping_event;
      logic                alert_trig, ping_trig, hs_timeout;
      logic [TimeoutW-1:0] hs_cnt_inc;

      assign ping_sigint = alert_rx_i[i].ping_p == alert_rx_i[i].ping_n;
      assign ack_sigint  = alert_rx_i[i].ack_p == alert_rx_i[i].ack_n;
      assign sigint      = ping_sigint | ack_sigint;
      assign ack_level   = alert_rx_i[i].ack_p;
      assign ping_event  = ~ping_sigint & (alert_rx_i[i].ping_p != ping_level_q);

      assign alert_trig  = alert_req_i[i] | set_q | alert_test_i[i] | test_q;
      assign ping_trig   = ping_event | ping_q;

      // hs_cnt holds the cycles already spent in the current phase, so the
      // timeout fires at the end of the timeout_cycles_i-th cycle.
      assign hs_cnt_inc  = hs_cnt + TimeoutW'(1);
      assign hs_timeout  = (timeout_cycles_i != '0) && (hs_cnt_inc == timeout_cycles_i);

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state        <= Idle;
            alert_p      <= 1'b0;
            alert_n      <= 1'b1;
            ping_level_q <= 1'b0;
            set_q        <= 1'b0;
            test_q       <= 1'b0;
            ping_q       <= 1'b0;
            alert_clr    <= 1'b0;
            ping_clr     <= 1'b0;
            timeout_q    <= 1'b0;
            hs_cnt       <= '0;
            pause_cnt    <= '0;
         end else begin
            if (!ping_sigint) ping_level_q <= alert_rx_i[i].ping_p;
            set_q  <= FatalMask[i] ? (alert_req_i[i] | set_q)
                                   : ((alert_req_i[i] | set_q) & ~alert_clr);
            test_q <= (alert_test_i[i] | test_q) & ~alert_clr;
            ping_q <= (ping_event | ping_q) & ~(ping_clr | sigint);
            alert_clr <= 1'b0;
            ping_clr  <= 1'b0;
            hs_cnt    <= hs_cnt_inc;
            if (timeout_clr_i[i]) timeout_q <= 1'b0;

            if (sigint) begin
               state    <= Idle;
               alert_p  <= 1'b0;
               alert_n  <= 1'b0;
               ping_clr <= 1'b1;
            end else begin
               case (state)
                  Idle: begin
                     hs_cnt  <= '0;
                     alert_p <= 1'b0;
                     alert_n <= 1'b1;
                     if (alert_trig) begin
                        state   <= AlertHs1;
                        alert_p <= 1'b1;
                        alert_n <= 1'b0;
                     end else if (ping_trig) begin
                        state   <= PingHs1;
                        alert_p <= 1'b1;
                        alert_n <= 1'b0;
                     end
                  end
                  AlertHs1, PingHs1: begin
                     if (ack_level) begin
                        state   <= (state == AlertHs1) ? AlertHs2 : PingHs2;
                        hs_cnt  <= '0;
                        alert_p <= 1'b0;
                        alert_n <= 1'b1;
                     end else if (hs_timeout) begin
                        state     <= Pause;
                        pause_cnt <= '0;
                        timeout_q <= 1'b1;
                        alert_p   <= 1'b0;
                        alert_n   <= 1'b1;
                     end else begin
                        alert_p <= 1'b1;
                        alert_n <= 1'b0;
                     end
                  end
                  AlertHs2, PingHs2: begin
                     alert_p <= 1'b0;
                     alert_n <= 1'b1;
                     if (!ack_level) begin
                        state     <= Pause;
                        pause_cnt <= '0;
                        alert_clr <= (state == AlertHs2);
                        ping_clr  <= (state == PingHs2);
                     end else if (hs_timeout) begin
                        state     <= Pause;
                        pause_cnt <= '0;
                        timeout_q <= 1'b1;
                     end
                  end
                  Pause: begin
                     alert_p <= 1'b0;
                     alert_n <= 1'b1;
                     if (pause_cnt == PauseLast) state <= Idle;
                     else pause_cnt <= pause_cnt + 4'd1;
                  end
                  default: begin
                     state   <= Idle;
                     alert_p <= 1'b0;
                     alert_n <= 1'b1;
                  end
               endcase
            end
         end
      end

      assign alert_tx_o[i]    = {alert_p, alert_n};
      assign alert_state_o[i] = set_q;
      assign alert_ack_o[i]   = alert_clr & set_q;
      assign timeout_o[i]     = timeout_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_caliptra_prim_alert_sender_mc.sv
`default_nettype none
// tb_caliptra_prim_alert_sender_mc: randomized scenarios checked cycle by cycle against
// a handshake-timing reference model.
module tb_caliptra_prim_alert_sender_mc;
   import caliptra_prim_alert_pkg::*;

   localparam int N    = 4;
   localparam int P    = 2;
   localparam int MAXC = 128;
   localparam logic [N-1:0] FATAL = 4'b0010;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   alert_test, alert_req, alert_ack, alert_state, timeout, timeout_clr;
   logic [7:0]     timeout_cycles;
   alert_rx_t      alert_rx [N];
   alert_tx_t      alert_tx [N];

   caliptra_prim_alert_sender_mc #(
      .NumAlerts(N), .FatalMask(FATAL), .PauseCycles(P), .TimeoutW(8)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .alert_test_i(alert_test), .alert_req_i(alert_req),
      .alert_ack_o(alert_ack), .alert_state_o(alert_state),
      .timeout_cycles_i(timeout_cycles), .timeout_o(timeout),
      .timeout_clr_i(timeout_clr),
      .alert_rx_i(alert_rx), .alert_tx_o(alert_tx)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int d;
   logic [N-1:0] lb;
   logic [N-1:0] e_p [MAXC], e_n [MAXC], e_ack [MAXC], e_st [MAXC], e_to [MAXC];
   logic [N-1:0] s_req [MAXC], s_test [MAXC], s_ping [MAXC], s_sig [MAXC], s_tclr [MAXC];
   logic [N-1:0] to_edge [MAXC], hist [MAXC];

   task automatic check(input string tag, input int n, input logic [N-1:0] obs,
                        input logic [N-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, n, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] tx_p();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = alert_tx[i].alert_p;
      return v;
   endfunction

   function automatic logic [N-1:0] tx_n();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = alert_tx[i].alert_n;
      return v;
   endfunction

   function automatic int period();
      return 2 * d + 3 + P;
   endfunction

   task automatic plan_clear();
      for (int n = 0; n < MAXC; n++) begin
         e_p[n] = '0; e_n[n] = '1; e_ack[n] = '0; e_st[n] = '0; e_to[n] = '0;
         s_req[n] = '0; s_test[n] = '0; s_ping[n] = '0; s_sig[n] = '0;
         s_tclr[n] = '0; to_edge[n] = '0;
      end
      lb = '1;
   endtask

   task automatic mark_hi(input int ch, input int s, input int len);
      for (int n = s; n < s + len && n < MAXC; n++) begin
         e_p[n][ch] = 1'b1;
         e_n[n][ch] = 1'b0;
      end
   endtask

   // A looped-back handshake: alert high for d+1 cycles, low phase d+1 cycles,
   // native completions pulse ack on the cycle the handshake ends.
   task automatic mark_loop_hs(input int ch, input int s, input bit native);
      mark_hi(ch, s, d + 1);
      if (native) begin
         if (s + 2 * d + 2 < MAXC) e_ack[s + 2 * d + 2][ch] = 1'b1;
         for (int n = s; n <= s + 2 * d + 2 && n < MAXC; n++) e_st[n][ch] = 1'b1;
      end
   endtask

   task automatic derive_timeout(input int ncyc);
      logic [N-1:0] f;
      f = '0;
      for (int n = 0; n < ncyc; n++) begin
         f = (f & ~s_tclr[n]) | to_edge[n];
         e_to[n] = f;
      end
   endtask

   task automatic run_plan(input int ncyc, input logic [7:0] tcyc);
      logic [N-1:0] lvl;
      logic         a;
      lvl = '0;
      timeout_cycles = tcyc;
      rst = 1'b1;
      alert_req = '0; alert_test = '0; timeout_clr = '0;
      for (int i = 0; i < N; i++) alert_rx[i] = '{1'b0, 1'b1, 1'b0, 1'b1};
      repeat (2) @(posedge clk);
      #1;
      check("rst_alert_p", -1, tx_p(), '0);
      check("rst_alert_n", -1, tx_n(), '1);
      check("rst_ack", -1, alert_ack, '0);
      check("rst_state", -1, alert_state, '0);
      check("rst_timeout", -1, timeout, '0);
      rst = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         alert_req   = s_req[n];
         alert_test  = s_test[n];
         timeout_clr = s_tclr[n];
         lvl = lvl ^ s_ping[n];
         for (int i = 0; i < N; i++) begin
            a = (lb[i] && (n - 1 - d) >= 0) ? hist[n - 1 - d][i] : 1'b0;
            if (s_sig[n][i]) alert_rx[i] = '{lvl[i], ~lvl[i], 1'b1, 1'b1};
            else             alert_rx[i] = '{lvl[i], ~lvl[i], a, ~a};
         end
         @(posedge clk);
         #1;
         hist[n] = tx_p();
         check("alert_p", n, tx_p(), e_p[n]);
         check("alert_n", n, tx_n(), e_n[n]);
         check("alert_ack", n, alert_ack, e_ack[n]);
         check("alert_state", n, alert_state, e_st[n]);
         check("timeout", n, timeout, e_to[n]);
      end
   endtask

   initial begin
      int rec [3];
      int c1, c2, s, s2, w, k, T, tp, ncyc;
      rec = '{0, 2, 3};

      // Independent native alerts on two recoverable channels
      for (int it = 0; it < 5; it++) begin
         plan_clear();
         d  = $urandom_range(1, 3);
         c1 = rec[$urandom_range(0, 2)];
         do c2 = rec[$urandom_range(0, 2)]; while (c2 == c1);
         s  = $urandom_range(1, 6);
         s2 = $urandom_range(1, 10);
         w  = $urandom_range(1, 3);
         for (int j = 0; j < w; j++) s_req[s + j][c1] = 1'b1;
         s_req[s2][c2] = 1'b1;
         mark_loop_hs(c1, s, 1'b1);
         mark_loop_hs(c2, s2, 1'b1);
         run_plan(30, 8'd0);
      end

      // Fatal channel repeats handshakes; ends mid-handshake, next reset aborts it
      plan_clear();
      d = $urandom_range(1, 3);
      s = $urandom_range(1, 4);
      s_req[s][1] = 1'b1;
      for (int j = 0; j < 3; j++) mark_loop_hs(1, s + j * period(), 1'b1);
      mark_hi(1, s + 3 * period(), 1);
      ncyc = s + 3 * period() + 1;
      for (int n = s; n < ncyc; n++) e_st[n][1] = 1'b1;
      run_plan(ncyc, 8'd0);

      // Test request: handshake without state or ack, on any channel
      plan_clear();
      d  = $urandom_range(1, 3);
      c1 = $urandom_range(0, N - 1);
      s  = $urandom_range(1, 5);
      s_test[s][c1] = 1'b1;
      mark_loop_hs(c1, s, 1'b0);
      run_plan(25, 8'd0);

      // Alert and ping together on ch2 (alert first), lone ping on ch0
      plan_clear();
      d  = $urandom_range(1, 3);
      s  = $urandom_range(1, 5);
      s2 = $urandom_range(1, 8);
      s_req[s][2]   = 1'b1;
      s_ping[s][2]  = 1'b1;
      s_ping[s2][0] = 1'b1;
      mark_loop_hs(2, s, 1'b1);
      mark_loop_hs(2, s + period(), 1'b0);
      mark_loop_hs(0, s2, 1'b0);
      run_plan(s + 2 * period() + 3, 8'd0);

      // Timeout on ch3 with ack stuck low: retries, clear, clear colliding with set
      plan_clear();
      d  = 1;
      T  = $urandom_range(3, 8);
      tp = T + P + 1;
      lb[3] = 1'b0;
      s = 2;
      s_req[s][3] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         mark_hi(3, s + j * tp, T);
         to_edge[s + j * tp + T][3] = 1'b1;
      end
      ncyc = s + 2 * tp + T + 2;
      for (int n = s; n < ncyc; n++) e_st[n][3] = 1'b1;
      s_tclr[s + T + 1][3] = 1'b1;
      for (int n = s + tp + T - 1; n <= s + tp + T + 1; n++) s_tclr[n][3] = 1'b1;
      derive_timeout(ncyc);
      run_plan(ncyc, 8'(T));

      // Ack signal-integrity fault mid-handshake on ch0, then retry
      plan_clear();
      d = 1;
      lb[0] = 1'b0;
      k = $urandom_range(1, 3);
      s_req[2][0] = 1'b1;
      mark_hi(0, 2, 2);
      for (int n = 4; n < 4 + k; n++) begin
         s_sig[n][0] = 1'b1;
         e_n[n][0]   = 1'b0;
      end
      mark_hi(0, 4 + k, MAXC);
      for (int n = 2; n < MAXC; n++) e_st[n][0] = 1'b1;
      run_plan(8 + k, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/caliptra_prim_alert_sender_mc.md
CALIPTRA_PRIM_ALERT_SENDER_MC -- requirements
Module: caliptra_prim_alert_sender_mc

Interface
REQ-001 Parameter NumAlerts, default 4, SHALL set the number of independent alert channels (1..32).
REQ-002 Parameter FatalMask, default '0, SHALL be a NumAlerts-bit mask; bit i=1 makes channel i latch alert_req_i[i] until reset.
REQ-003 Parameter PauseCycles, default 2, SHALL set the idle cycles between handshakes (1..15).
REQ-004 Parameter TimeoutW, default 8, SHALL set the width of the handshake timeout counter.
REQ-005 Port clk_i, input, 1, SHALL be the single clock; all flops rise on it.
REQ-006 Port rst_i, input, 1, SHALL be a synchronous, active-high reset.
REQ-007 Port alert_test_i, input, NumAlerts, SHALL request one non-latched test handshake per channel.
REQ-008 Port alert_req_i, input, NumAlerts, SHALL carry native alert requests.
REQ-009 Port alert_ack_o, output, NumAlerts, SHALL pulse when a native alert handshake completes.
REQ-010 Port alert_state_o, output, NumAlerts, SHALL reflect the alert latching register per channel.
REQ-011 Port timeout_cycles_i, input, TimeoutW, SHALL set the handshake timeout; 0 disables it.
REQ-012 Port timeout_o, output, NumAlerts, SHALL hold sticky per-channel handshake-timeout flags.
REQ-013 Port timeout_clr_i, input, NumAlerts, SHALL clear the matching timeout_o bits.
REQ-014 Port alert_rx_i, input, alert_rx_t[NumAlerts], SHALL carry ping_p/n and ack_p/n per channel.
REQ-015 Port alert_tx_o, output, alert_tx_t[NumAlerts], SHALL carry alert_p/n per channel.

Function
REQ-016 Each channel SHALL operate independently, with no shared state except timeout_cycles_i.
REQ-017 Synchronous diff decode: sigint SHALL be p==n; level SHALL be p; ping event SHALL be a ping level change vs the registered level, evaluated only when the pair is not sigint.
REQ-018 Request latch: set = alert_req_i | set_q; fatal channels SHALL never clear it; recoverable channels SHALL clear it on alert_clr.
REQ-019 Test latch: set = alert_test_i | test_q, cleared on alert_clr; the test latch SHALL never affect alert_state_o or alert_ack_o.
REQ-020 Ping latch: set on ping event, cleared on ping_clr or sigint.
REQ-021 FSM states SHALL be Idle, AlertHs1, AlertHs2, PingHs1, PingHs2, Pause; illegal encodings SHALL go to Idle.
REQ-022 Idle: an alert or test trigger SHALL go to AlertHs1, otherwise a ping trigger SHALL go to PingHs1; alert SHALL win when both occur in the same cycle; alert_p/n SHALL be 1/0 the next cycle.
REQ-023 Hs1: drive 1/0 until ack_level=1, then go to Hs2 and drive 0/1.
REQ-024 Hs2: when ack_level=0, go to Pause and assert alert_clr (alert) or ping_clr (ping) for one cycle.
REQ-025 Pause SHALL last exactly PauseCycles cycles, then go to Idle.
REQ-026 alert_ack_o[i] SHALL be alert_clr & set_q, a single-cycle pulse.
REQ-027 Timeout: a counter SHALL run in Hs1/Hs2 and reset on state entry; when it equals timeout_cycles_i (nonzero), the channel SHALL set timeout_o, go to Pause, drive 0/1, and leave the alert/test latches uncleared so a retry follows.
REQ-028 If timeout_clr_i and a new timeout occur in the same cycle, set SHALL win.
REQ-029 If sigint is on ack or ping, the next state SHALL be Idle, alert_p/n SHALL be 0/0, ping_clr SHALL assert and alert_clr SHALL not; this SHALL override all states, including Pause and timeout.
REQ-030 Output SHALL be registered: latency from trigger to alert_p rise is 1 cycle from Idle.

Reset
REQ-031 While rst_i=1 at a clock edge, every channel SHALL set state=Idle, clear all latches and counters, set alert_p/n=0/1, and set alert_ack_o=0, alert_state_o=0, timeout_o=0, and decoded levels=0.
REQ-032 Reset asserted mid-handshake SHALL abort it the next edge with no ack pulse.

Verification
REQ-033 Loopback ch0 (ack<=alert delayed 1), alert_req_i[0] pulsed 1 cycle -> alert_p rises next cycle, one alert_ack_o[0] pulse, then alert_state_o[0]=0.
REQ-034 FatalMask=4'b0010, req[1] pulsed -> alert_state_o[1] stays 1, handshakes repeat every handshake+PauseCycles until rst_i.
REQ-035 ping_p toggled on ch2 with alert_req_i[2] asserted the same cycle -> the alert handshake runs first, then the ping handshake.
REQ-036 timeout_cycles_i=5, ack held 0 on ch3 -> timeout_o[3]=1 after 5 cycles in Hs1, Pause, then retry; timeout_clr_i[3] clears it.
REQ-037 ack_p=ack_n=1 on ch0 mid-Hs1 -> alert_p/n=0/0 the next cycle, then Idle; the pending alert is retried once sigint clears.
